// File: rtl/vend_pkg.sv
// vend_pkg: definitions shared by the coin-counting vending FSM and its
// downstream dispense controller.
//   state_t  - dispense controller states (IDLE..FAULT)
//   coin_t   - coin codes seen by the upstream counter
//   DEF_*    - default timing constants
//   max3     - helper used to size down-counters
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOTOR     = 3'd1,
    WAIT_DROP = 3'd2,
    EJECT     = 3'd3,
    FAULT     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    COIN_NONE   = 2'd0,
    COIN_TEN    = 2'd1,
    COIN_TWENTY = 2'd2,
    COIN_FIFTY  = 2'd3
  } coin_t;

  localparam int DEF_MOTOR_CYCLES   = 8;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int DEF_EJECT_CYCLES   = 4;
  localparam int DEF_QDEPTH         = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vend_req_fifo.sv
// vend_req_fifo: 1-bit-wide synchronous FIFO holding the change-owed flag of
// each queued vend. Head data is presented combinationally.
//   i_clk, i_rst    clock, async active-high reset
//   i_push, i_din   write request and data (ignored when full)
//   i_pop           read request (ignored when empty)
//   o_dout          head entry
//   o_full/o_empty  occupancy flags
//   o_count         occupancy 0..DEPTH
module vend_req_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_din,
  input  logic                   i_pop,
  output logic                   o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];

  // Flags come from the pre-edge count, so a push on a full FIFO is refused
  // even if a pop happens on the same edge.
  assign w_wr = i_push && !o_full;
  assign w_rd = i_pop && !o_empty;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_rd)
        r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: queues vend pulses from the coin FSM, runs the product
// motor, waits (with timeout) for the drop sensor, then runs the change
// ejector if change is owed.
//   clk, reset       clock, async active-high reset
//   Z, change_given  vend pulse and its change-owed flag
//   drop_sensor      product-drop detector (synchronised)
//   fault_clr        operator clear, used only in FAULT
//   motor_on, eject_on, fault   Moore drives decoded from state
//   vend_done        Mealy pulse on the completing transition
//   busy             FSM active or vends queued
//   overflow         sticky, request lost to a full queue
//   pending          queue occupancy
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES   = DEF_MOTOR_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int EJECT_CYCLES   = DEF_EJECT_CYCLES,
  parameter int QDEPTH         = DEF_QDEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    Z,
  input  logic                    change_given,
  input  logic                    drop_sensor,
  input  logic                    fault_clr,
  output logic                    motor_on,
  output logic                    eject_on,
  output logic                    busy,
  output logic                    vend_done,
  output logic                    fault,
  output logic                    overflow,
  output logic [$clog2(QDEPTH):0] pending
);

  localparam int CNT_MAX = max3(MOTOR_CYCLES, TIMEOUT_CYCLES, EJECT_CYCLES);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t          r_state, w_nxt_state;
  logic [CW-1:0]   r_cnt, w_nxt_cnt;
  logic            r_cur_change;
  logic            r_ovf;
  logic            w_pop;
  logic            w_done;
  logic            w_head;
  logic            w_full;
  logic            w_empty;

  vend_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_push  (Z),
    .i_din   (change_given),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (pending)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_cur_change <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      if (w_pop)
        r_cur_change <= w_head;
      if (Z && w_full)
        r_ovf <= 1'b1;
    end
  end

  // The counter always transitions at zero, so it never wraps below.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nxt_cnt   = CW'(MOTOR_CYCLES - 1);
          w_nxt_state = MOTOR;
        end
      end
      MOTOR: begin
        if (r_cnt == '0) begin
          w_nxt_cnt   = CW'(TIMEOUT_CYCLES - 1);
          w_nxt_state = WAIT_DROP;
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      WAIT_DROP: begin
        // A drop arriving on the last timeout cycle still counts as success.
        if (drop_sensor) begin
          if (r_cur_change) begin
            w_nxt_cnt   = CW'(EJECT_CYCLES - 1);
            w_nxt_state = EJECT;
          end else begin
            w_done      = 1'b1;
            w_nxt_state = IDLE;
          end
        end else if (r_cnt == '0) begin
          w_nxt_state = FAULT;
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      EJECT: begin
        if (r_cnt == '0) begin
          w_done      = 1'b1;
          w_nxt_state = IDLE;
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      FAULT: begin
        // The vend in flight is abandoned; queued vends wait in the FIFO.
        if (fault_clr)
          w_nxt_state = IDLE;
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  assign motor_on  = (r_state == MOTOR);
  assign eject_on  = (r_state == EJECT);
  assign fault     = (r_state == FAULT);
  assign vend_done = w_done;
  assign busy      = (r_state != IDLE) || !w_empty;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench for vend_dispense_ctrl: directed scenarios plus a
// randomized run, each cycle compared against a queue-based reference model.
module tb_vend_dispense_ctrl;

  localparam int MOTOR_C   = 8;
  localparam int TIMEOUT_C = 64;
  localparam int EJECT_C   = 4;
  localparam int QD        = 4;

  localparam int P_IDLE  = 0;
  localparam int P_MOTOR = 1;
  localparam int P_WAIT  = 2;
  localparam int P_EJECT = 3;
  localparam int P_FAULT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       Z, change_given, drop_sensor, fault_clr;
  logic       motor_on, eject_on, busy, vend_done, fault, overflow;
  logic [2:0] pending;
  logic [8:0] dut_o;

  assign dut_o = {motor_on, eject_on, busy, vend_done, fault, overflow, pending};

  vend_dispense_ctrl #(
    .MOTOR_CYCLES  (MOTOR_C),
    .TIMEOUT_CYCLES(TIMEOUT_C),
    .EJECT_CYCLES  (EJECT_C),
    .QDEPTH        (QD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Z           (Z),
    .change_given(change_given),
    .drop_sensor (drop_sensor),
    .fault_clr   (fault_clr),
    .motor_on    (motor_on),
    .eject_on    (eject_on),
    .busy        (busy),
    .vend_done   (vend_done),
    .fault       (fault),
    .overflow    (overflow),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: queue of change flags, phase and cycles spent in phase
  bit q[$];
  int m_ph;
  int m_t;
  bit m_cur;
  bit m_ovf;

  // observations of the DUT, used by directed checks
  int       n_motor, n_eject, n_fault, n_done, n_dej;
  bit       saw_ej;
  bit [4:0] vlog;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_ph  = P_IDLE;
    m_t   = 0;
    m_cur = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic clr_obs();
    n_motor = 0; n_eject = 0; n_fault = 0; n_done = 0; n_dej = 0;
    saw_ej = 1'b0; vlog = '0;
  endtask

  task automatic model_step(input bit z, input bit cg, input bit ds, input bit fc);
    bit full_pre;
    full_pre = (q.size() == QD);
    case (m_ph)
      P_IDLE:  if (q.size() != 0) begin m_cur = q.pop_front(); m_ph = P_MOTOR; m_t = 0; end
      P_MOTOR: begin m_t++; if (m_t == MOTOR_C) begin m_ph = P_WAIT; m_t = 0; end end
      P_WAIT: begin
        if (ds) begin
          if (m_cur) begin m_ph = P_EJECT; m_t = 0; end
          else m_ph = P_IDLE;
        end else if (m_t == TIMEOUT_C - 1) m_ph = P_FAULT;
        else m_t++;
      end
      P_EJECT: begin m_t++; if (m_t == EJECT_C) m_ph = P_IDLE; end
      default: if (fc) m_ph = P_IDLE;
    endcase
    if (z) begin
      if (full_pre) m_ovf = 1'b1;
      else q.push_back(cg);
    end
  endtask

  // Drive one cycle of inputs, compare all outputs to the model, advance.
  task automatic cycle(input bit z, input bit cg, input bit ds, input bit fc);
    logic [8:0] exp_o;
    bit         done_e;
    Z = z; change_given = cg; drop_sensor = ds; fault_clr = fc;
    #1;
    done_e = (m_ph == P_WAIT && ds && !m_cur) || (m_ph == P_EJECT && m_t == EJECT_C - 1);
    exp_o  = {m_ph == P_MOTOR, m_ph == P_EJECT, (m_ph != P_IDLE) || (q.size() != 0),
              done_e, m_ph == P_FAULT, m_ovf, 3'(q.size())};
    chk("outs", dut_o, exp_o);
    if (motor_on) n_motor++;
    if (eject_on) begin n_eject++; saw_ej = 1'b1; end
    if (fault) n_fault++;
    if (vend_done) begin
      n_done++;
      if (eject_on) n_dej++;
      vlog   = {vlog[3:0], saw_ej};
      saw_ej = 1'b0;
    end
    model_step(z, cg, ds, fc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Run until the model is idle with an empty queue, dropping promptly.
  task automatic drain();
    int k;
    k = 0;
    while ((m_ph != P_IDLE || q.size() != 0) && k < 400) begin
      cycle(1'b0, 1'b0, (m_ph == P_WAIT && m_t == 1), (m_ph == P_FAULT));
      k++;
    end
    chk("drain_bound", (k < 400), 1);
  endtask

  // Assert reset between edges and confirm the drives drop immediately.
  task automatic mid_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_motor"}, motor_on, 0);
    chk({tag, "_eject"}, eject_on, 0);
    chk({tag, "_pend"},  pending,  0);
    chk({tag, "_ovf"},   overflow, 0);
    chk({tag, "_busy"},  busy,     0);
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  bit pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    reset = 1'b1; Z = 0; change_given = 0; drop_sensor = 0; fault_clr = 0;
    model_reset();
    clr_obs();
    #3;
    chk("reset_outs", dut_o, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // single vend, no change, drop 3 cycles after motor stops
    clr_obs();
    cycle(1, 0, 0, 0);
    idle(12);
    cycle(0, 0, 1, 0);
    idle(2);
    chk("s1_motor_cycles", n_motor, MOTOR_C);
    chk("s1_done",         n_done, 1);
    chk("s1_no_eject",     n_eject, 0);
    chk("s1_busy",         busy, 0);

    // vend with change, drop on first wait cycle
    clr_obs();
    cycle(1, 1, 0, 0);
    idle(9);
    cycle(0, 0, 1, 0);
    idle(5);
    chk("s2_eject_cycles", n_eject, EJECT_C);
    chk("s2_done",         n_done, 1);
    chk("s2_done_in_ej",   n_dej, 1);

    // timeout into fault, push while faulted, clear, queued vend starts
    clr_obs();
    cycle(1, 0, 0, 0);
    idle(9);
    idle(TIMEOUT_C);
    chk("s3_no_early_fault", n_fault, 0);
    cycle(1, 1, 0, 0);
    chk("s3_fault_seen", n_fault, 1);
    chk("s3_pending",    pending, 1);
    cycle(0, 0, 0, 1);
    chk("s3_idle_after_clr", motor_on, 0);
    idle(1);
    chk("s3_motor_restart", motor_on, 1);
    drain();

    // queue full / overflow, five vends complete in order
    clr_obs();
    for (int i = 0; i < 6; i++) cycle(1, pat[i], 0, 0);
    chk("s4_pending_full", pending, QD);
    chk("s4_overflow",     overflow, 1);
    drain();
    chk("s4_done_count", n_done, 5);
    chk("s4_change_order", vlog, 5'b10110);

    // drop on the same cycle the timeout expires
    clr_obs();
    cycle(1, 0, 0, 0);
    idle(9);
    idle(TIMEOUT_C - 1);
    cycle(0, 0, 1, 0);
    idle(2);
    chk("s5_no_fault", n_fault, 0);
    chk("s5_done",     n_done, 1);
    // push coinciding with pop keeps occupancy
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    chk("s5_push_pop_pend", pending, 1);
    drain();

    // reset mid-motor (overflow is still set from earlier) and mid-eject
    cycle(1, 1, 0, 0);
    idle(3);
    mid_reset("s6_rst_motor");
    cycle(1, 1, 0, 0);
    idle(9);
    cycle(0, 0, 1, 0);
    idle(1);
    mid_reset("s6_rst_eject");
    idle(2);
    chk("s6_quiet", dut_o, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      cycle(($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
    // rarer drops to exercise timeouts
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 79) == 0), ($urandom_range(0, 7) == 0));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
